// File: rtl/lag_pl_trunk_arbiter_if.sv
// rtl/lag_pl_trunk_arbiter_if.sv - request/grant, link ownership and credit signals of one output trunk
interface lag_pl_trunk_arbiter_if #(
    parameter int num_req   = 10,
    parameter int num_links = 2,
    parameter int rw        = (num_req > 1) ? $clog2(num_req) : 1
);
    logic [num_req-1:0]           req;
    logic [num_req-1:0]           grant;
    logic [num_req*num_links-1:0] grant_link;
    logic [num_links-1:0]         flit_sent;
    logic [num_links-1:0]         flit_tail;
    logic [num_links-1:0]         credit_in;
    logic [num_links*rw-1:0]      link_owner;
    logic [num_links-1:0]         link_busy;
    logic [num_links-1:0]         can_send;
    logic                         err;

    modport master (
        output req, flit_sent, flit_tail, credit_in,
        input  grant, grant_link, link_owner, link_busy, can_send, err
    );

    modport slave (
        input  req, flit_sent, flit_tail, credit_in,
        output grant, grant_link, link_owner, link_busy, can_send, err
    );
endinterface

// File: rtl/lag_pl_trunk_arbiter.sv
// rtl/lag_pl_trunk_arbiter.sv - round-robin PL allocator and per-PL credit tracker for one output trunk
module lag_pl_trunk_arbiter #(
    parameter int num_req         = 10,
    parameter int num_links       = 2,
    parameter int buf_len         = 4,
    parameter int only_when_empty = 0,
    parameter int cw              = $clog2(buf_len + 1),
    parameter int rw              = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lag_pl_trunk_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } pl_state_t;

    localparam logic [cw-1:0] full_credits = cw'(buf_len);

    pl_state_t                    r_state      [num_links];
    logic [cw-1:0]                r_credits    [num_links];
    logic [rw-1:0]                r_owner      [num_links];
    logic [rw-1:0]                r_rr_ptr;
    logic [num_req-1:0]           r_grant;
    logic [num_req*num_links-1:0] r_grant_link;
    logic                         r_err;

    pl_state_t                    w_state_nx   [num_links];
    logic [cw-1:0]                w_credits_nx [num_links];
    logic [rw-1:0]                w_owner_nx   [num_links];
    logic [rw-1:0]                w_rr_nx;
    logic [num_req-1:0]           w_grant_nx;
    logic [num_req*num_links-1:0] w_grant_link_nx;
    logic                         w_err_nx;
    logic [num_req-1:0]           w_owned;
    logic [num_req-1:0]           w_eligible;
    logic [num_links-1:0]         w_alloc_ok;

    // A requester already holding a bound PL must not be granted a second one.
    always_comb begin
        w_owned = '0;
        for (int r = 0; r < num_req; r++) begin
            for (int j = 0; j < num_links; j++) begin
                if (r_state[j] != ST_FREE && r_owner[j] == rw'(r)) begin
                    w_owned[r] = 1'b1;
                end
            end
        end
        w_eligible = bus.req & ~w_owned;
    end

    always_comb begin
        for (int j = 0; j < num_links; j++) begin
            w_alloc_ok[j] = (r_state[j] == ST_FREE) &&
                            ((only_when_empty == 0) || (r_credits[j] == full_credits));
        end
    end

    always_comb begin
        logic [num_links-1:0] taken;
        int                   idx;
        logic                 placed;

        taken           = '0;
        idx             = 0;
        placed          = 1'b0;
        w_err_nx        = r_err;
        w_rr_nx         = r_rr_ptr;
        w_grant_nx      = '0;
        w_grant_link_nx = '0;

        for (int j = 0; j < num_links; j++) begin
            w_state_nx[j]   = r_state[j];
            w_credits_nx[j] = r_credits[j];
            w_owner_nx[j]   = r_owner[j];

            if (bus.flit_sent[j] && r_state[j] == ST_FREE) begin
                w_err_nx = 1'b1;
            end

            // Simultaneous send and return cancel out, even at the limits.
            if (bus.flit_sent[j] && !bus.credit_in[j]) begin
                if (r_credits[j] == '0) begin
                    w_err_nx = 1'b1;
                end else begin
                    w_credits_nx[j] = r_credits[j] - 1'b1;
                end
            end else if (bus.credit_in[j] && !bus.flit_sent[j]) begin
                if (r_credits[j] == full_credits) begin
                    w_err_nx = 1'b1;
                end else begin
                    w_credits_nx[j] = r_credits[j] + 1'b1;
                end
            end

            case (r_state[j])
                ST_BUSY: begin
                    if (bus.flit_sent[j] && bus.flit_tail[j]) begin
                        w_state_nx[j] = (only_when_empty != 0) ? ST_DRAIN : ST_FREE;
                    end
                end
                ST_DRAIN: begin
                    if (w_credits_nx[j] == full_credits) begin
                        w_state_nx[j] = ST_FREE;
                    end
                end
                default: ;
            endcase
        end

        // Walk requesters circularly from rr_ptr, pairing each with the lowest free PL left.
        for (int k = 0; k < num_req; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (w_eligible[idx]) begin
                placed = 1'b0;
                for (int j = 0; j < num_links; j++) begin
                    if (!placed && w_alloc_ok[j] && !taken[j]) begin
                        placed                              = 1'b1;
                        taken[j]                            = 1'b1;
                        w_grant_nx[idx]                     = 1'b1;
                        w_grant_link_nx[idx*num_links + j]  = 1'b1;
                        w_state_nx[j]                       = ST_BUSY;
                        w_owner_nx[j]                       = rw'(idx);
                        w_rr_nx                             = rw'((idx + 1) % num_req);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < num_links; j++) begin
                r_state[j]   <= ST_FREE;
                r_credits[j] <= full_credits;
                r_owner[j]   <= '0;
            end
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_grant_link <= '0;
            r_err        <= 1'b0;
        end else begin
            for (int j = 0; j < num_links; j++) begin
                r_state[j]   <= w_state_nx[j];
                r_credits[j] <= w_credits_nx[j];
                r_owner[j]   <= w_owner_nx[j];
            end
            r_rr_ptr     <= w_rr_nx;
            r_grant      <= w_grant_nx;
            r_grant_link <= w_grant_link_nx;
            r_err        <= w_err_nx;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.grant_link = r_grant_link;
    assign bus.err        = r_err;

    for (genvar j = 0; j < num_links; j++) begin : g_link_out
        assign bus.link_owner[j*rw +: rw] = r_owner[j];
        assign bus.link_busy[j]           = (r_state[j] != ST_FREE);
        assign bus.can_send[j]            = (r_state[j] != ST_FREE) && (r_credits[j] != '0);
    end

endmodule

// File: tb/tb_lag_pl_trunk_arbiter.sv
// tb/tb_lag_pl_trunk_arbiter.sv - directed and random checks of the trunk arbiter against a queue-based model
module tb_lag_pl_trunk_arbiter;

    localparam int NR    = 10;
    localparam int NL    = 2;
    localparam int BL    = 4;
    localparam int RW    = 4;
    localparam int FREE  = 0;
    localparam int BUSY  = 1;
    localparam int DRAIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lag_pl_trunk_arbiter_if #(.num_req(NR), .num_links(NL), .rw(RW)) if0 ();
    lag_pl_trunk_arbiter_if #(.num_req(NR), .num_links(NL), .rw(RW)) if1 ();

    lag_pl_trunk_arbiter #(.num_req(NR), .num_links(NL), .buf_len(BL), .only_when_empty(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    lag_pl_trunk_arbiter #(.num_req(NR), .num_links(NL), .buf_len(BL), .only_when_empty(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    logic [1:0][NR-1:0]    s_req;
    logic [1:0][NL-1:0]    s_sent, s_tail, s_cred;
    logic [1:0][NR-1:0]    o_grant;
    logic [1:0][NR*NL-1:0] o_gl;
    logic [1:0][NL*RW-1:0] o_owner;
    logic [1:0][NL-1:0]    o_busy, o_can;
    logic [1:0]            o_err;

    assign if0.req = s_req[0];  assign if0.flit_sent = s_sent[0];
    assign if0.flit_tail = s_tail[0];  assign if0.credit_in = s_cred[0];
    assign if1.req = s_req[1];  assign if1.flit_sent = s_sent[1];
    assign if1.flit_tail = s_tail[1];  assign if1.credit_in = s_cred[1];
    assign o_grant[0] = if0.grant;  assign o_gl[0] = if0.grant_link;  assign o_owner[0] = if0.link_owner;
    assign o_busy[0] = if0.link_busy;  assign o_can[0] = if0.can_send;  assign o_err[0] = if0.err;
    assign o_grant[1] = if1.grant;  assign o_gl[1] = if1.grant_link;  assign o_owner[1] = if1.link_owner;
    assign o_busy[1] = if1.link_busy;  assign o_can[1] = if1.can_send;  assign o_err[1] = if1.err;

    int m_st  [2][NL];
    int m_cr  [2][NL];
    int m_own [2][NL];
    int m_rr  [2];
    bit [1:0] m_err;
    logic [1:0][NR-1:0]    m_grant;
    logic [1:0][NR*NL-1:0] m_gl;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset(input int u);
        for (int j = 0; j < NL; j++) begin
            m_st[u][j] = FREE; m_cr[u][j] = BL; m_own[u][j] = 0;
        end
        m_rr[u] = 0; m_err[u] = 1'b0; m_grant[u] = '0; m_gl[u] = '0;
    endtask

    // Unit 1 is the only_when_empty=1 instance.
    task automatic model_step(input int u);
        int nst [NL];
        int ncr [NL];
        int nown[NL];
        int qr[$];
        int ql[$];
        bit owned, s, t, c;
        int r, jl;
        for (int j = 0; j < NL; j++) begin
            s = s_sent[u][j]; t = s_tail[u][j]; c = s_cred[u][j];
            nst[j] = m_st[u][j]; ncr[j] = m_cr[u][j]; nown[j] = m_own[u][j];
            if (s && m_st[u][j] == FREE) m_err[u] = 1'b1;
            if (s && !c) begin
                if (m_cr[u][j] == 0) m_err[u] = 1'b1; else ncr[j] = ncr[j] - 1;
            end
            if (c && !s) begin
                if (m_cr[u][j] == BL) m_err[u] = 1'b1; else ncr[j] = ncr[j] + 1;
            end
            if (m_st[u][j] == BUSY && s && t) nst[j] = (u == 1) ? DRAIN : FREE;
            if (m_st[u][j] == DRAIN && ncr[j] == BL) nst[j] = FREE;
        end
        for (int k = 0; k < NR; k++) begin
            r = (m_rr[u] + k) % NR;
            owned = 1'b0;
            for (int j = 0; j < NL; j++)
                if (m_st[u][j] != FREE && m_own[u][j] == r) owned = 1'b1;
            if (s_req[u][r] && !owned) qr.push_back(r);
        end
        for (int j = 0; j < NL; j++)
            if (m_st[u][j] == FREE && (u == 0 || m_cr[u][j] == BL)) ql.push_back(j);
        m_grant[u] = '0; m_gl[u] = '0;
        while (qr.size() > 0 && ql.size() > 0) begin
            r = qr.pop_front(); jl = ql.pop_front();
            m_grant[u][r] = 1'b1; m_gl[u][r*NL + jl] = 1'b1;
            nst[jl] = BUSY; nown[jl] = r; m_rr[u] = (r + 1) % NR;
        end
        for (int j = 0; j < NL; j++) begin
            m_st[u][j] = nst[j]; m_cr[u][j] = ncr[j]; m_own[u][j] = nown[j];
        end
    endtask

    task automatic check_all(input int u);
        logic [NL*RW-1:0] eo;
        logic [NL-1:0]    eb, ec;
        for (int j = 0; j < NL; j++) begin
            eo[j*RW +: RW] = m_own[u][j][RW-1:0];
            eb[j] = (m_st[u][j] != FREE);
            ec[j] = (m_st[u][j] != FREE) && (m_cr[u][j] != 0);
        end
        chk($sformatf("u%0d.grant", u), 64'(o_grant[u]), 64'(m_grant[u]));
        chk($sformatf("u%0d.grant_link", u), 64'(o_gl[u]), 64'(m_gl[u]));
        chk($sformatf("u%0d.link_owner", u), 64'(o_owner[u]), 64'(eo));
        chk($sformatf("u%0d.link_busy", u), 64'(o_busy[u]), 64'(eb));
        chk($sformatf("u%0d.can_send", u), 64'(o_can[u]), 64'(ec));
        chk($sformatf("u%0d.err", u), 64'(o_err[u]), 64'(m_err[u]));
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk); #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        @(posedge clk); #1;
        check_all(0);
        check_all(1);
        rst = 1'b0;
    endtask

    initial begin
        int order[$];
        logic [NR-1:0] done_mask;
        s_req = '0; s_sent = '0; s_tail = '0; s_cred = '0;

        do_reset();
        chk("rst.busy", 64'(o_busy[0]), 64'd0);
        chk("rst.can_send", 64'(o_can[0]), 64'd0);
        chk("rst.grant", 64'(o_grant[0]), 64'd0);

        // Overflow: credit returned on a full PL.
        s_cred[0] = 2'b01;
        step();
        chk("ovf.err", 64'(o_err[0]), 64'd1);
        s_cred[0] = '0;
        do_reset();

        // Two simultaneous grants in ascending link order.
        s_req[0] = 10'b0000000110;
        step();
        chk("two.grant", 64'(o_grant[0]), 64'h006);
        chk("two.grant_link", 64'(o_gl[0]), 64'h24);
        chk("two.busy", 64'(o_busy[0]), 64'd3);
        s_req[0] = '0;

        // Release by tail, then a waiting requester takes the freed PL.
        s_req[0][5] = 1'b1;
        step();
        chk("wait.grant", 64'(o_grant[0]), 64'd0);
        s_sent[0] = 2'b01; s_tail[0] = 2'b01;
        step();
        chk("tail.busy", 64'(o_busy[0]), 64'd2);
        s_sent[0] = '0; s_tail[0] = '0;
        step();
        chk("realloc.grant", 64'(o_grant[0]), 64'h020);
        chk("realloc.owner0", 64'(o_owner[0][RW-1:0]), 64'd5);
        s_req[0] = '0;

        // Fairness: every requester granted once, in index order.
        do_reset();
        done_mask = '0;
        for (int c = 0; c < 10; c++) begin
            s_req[0] = ~done_mask;
            step();
            s_sent[0] = '0; s_tail[0] = '0; s_cred[0] = '0;
            for (int r = 0; r < NR; r++) begin
                if (o_grant[0][r]) begin
                    order.push_back(r);
                    for (int j = 0; j < NL; j++)
                        if (o_gl[0][r*NL + j]) begin
                            s_sent[0][j] = 1'b1; s_tail[0][j] = 1'b1; s_cred[0][j] = 1'b1;
                        end
                end
            end
            done_mask = done_mask | o_grant[0];
        end
        s_req[0] = '0;
        step();
        s_sent[0] = '0; s_tail[0] = '0; s_cred[0] = '0;
        chk("fair.count", 64'(order.size()), 64'd10);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("fair.order%0d", i), 64'(order[i]), 64'(i));

        // Credit exhaustion, underflow and simultaneous send+return.
        do_reset();
        s_req[0] = 10'b1;
        step();
        s_req[0] = '0;
        s_sent[0] = 2'b01;
        repeat (4) step();
        chk("cred.empty.can_send", 64'(o_can[0][0]), 64'd0);
        chk("cred.empty.err", 64'(o_err[0]), 64'd0);
        step();
        chk("cred.underflow.err", 64'(o_err[0]), 64'd1);
        s_sent[0] = '0; s_cred[0] = 2'b01;
        repeat (2) step();
        s_sent[0] = 2'b01;
        step();
        s_cred[0] = '0;
        step();
        chk("cred.hold.can_send1", 64'(o_can[0][0]), 64'd1);
        step();
        chk("cred.hold.can_send0", 64'(o_can[0][0]), 64'd0);
        s_sent[0] = '0;

        // only_when_empty: tail with credits outstanding drains before release.
        do_reset();
        s_req[1] = 10'b0010001000;
        step();
        chk("owe.grant", 64'(o_grant[1]), 64'h088);
        s_req[1] = '0;
        s_sent[1] = 2'b01;
        step();
        s_tail[1] = 2'b01;
        step();
        chk("owe.drain.busy", 64'(o_busy[1]), 64'd3);
        s_sent[1] = '0; s_tail[1] = '0;
        s_req[1][4] = 1'b1; s_cred[1] = 2'b01;
        step();
        chk("owe.drain1.busy", 64'(o_busy[1]), 64'd3);
        step();
        chk("owe.free.busy", 64'(o_busy[1]), 64'd2);
        s_cred[1] = '0;
        step();
        chk("owe.regrant", 64'(o_grant[1]), 64'h010);
        chk("owe.owner0", 64'(o_owner[1][RW-1:0]), 64'd4);
        s_req[1] = '0;

        // Random traffic on both instances, mostly protocol-clean.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int u = 0; u < 2; u++) begin
                s_req[u] = NR'($urandom);
                for (int j = 0; j < NL; j++) begin
                    s_sent[u][j] = (m_st[u][j] != FREE) && (m_cr[u][j] != 0) && ($urandom_range(0, 1) == 1);
                    s_tail[u][j] = ($urandom_range(0, 2) == 0);
                    s_cred[u][j] = (m_cr[u][j] < BL) && ($urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 99) == 0) s_sent[u][j] = 1'b1;
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lag_pl_trunk_arbiter.md
Name: lag_pl_trunk_arbiter

Overview:
- Per-output-trunk physical-link (PL) allocator and credit tracker for the LAG router.
- Shares the num_links output PLs of one output trunk among num_req input PLs that have requested that trunk.
- Binds one requester to one free output PL with round-robin fairness. Holds the binding until the packet tail leaves.
- Tracks downstream credits per PL and gates sending.

Parameters:
num_req, 10, number of requesting input PLs (all input ports x links)
num_links, 2, output PLs in this trunk (>=1)
buf_len, 4, downstream FIFO depth = initial credits per PL
only_when_empty, 0, 1 = PL returns to pool only after all credits are back
cw, $clog2(buf_len+1), credit counter width (derived)
rw, $clog2(num_req), requester index width (derived, min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  num_req  PL allocation request, held until grant
grant  out  num_req  one-cycle pulse: requester bound to a PL
grant_link  out  num_req*num_links  one-hot PL index per requester, valid while grant=1
flit_sent  in  num_links  a flit leaves on PL j this cycle
flit_tail  in  num_links  flit leaving on PL j is a tail (qualified by flit_sent)
credit_in  in  num_links  downstream freed one slot on PL j
link_owner  out  num_links*rw  bound requester index per PL
link_busy  out  num_links  PL j is bound (BUSY or DRAIN)
can_send  out  num_links  link_busy[j] & credits[j]!=0
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): every PL in FREE; credits=buf_len; rr_ptr=0; grant=0; grant_link=0; link_owner=0; link_busy=0; can_send=0; err=0.
- Per-PL FSM:
  - FREE -> BUSY on allocation.
  - BUSY -> FREE when flit_sent&flit_tail, if only_when_empty=0.
  - BUSY -> DRAIN on tail, if only_when_empty=1.
  - DRAIN -> FREE when the next-state credit count equals buf_len (DRAIN->FREE in the same cycle as the last credit_in).
  - With only_when_empty=1, FREE also requires credits==buf_len to be allocatable.
- Eligible requester: req=1 and not currently owner of any bound PL.
- Allocation, combinational from current state, registered results:
  - Scan eligible requesters circularly from rr_ptr.
  - Assign them in order to allocatable PLs in ascending index.
  - Grants per cycle = min(eligible, allocatable).
- Grant latency: req seen at edge N -> grant pulse and link_busy=1 after edge N+1. A PL released by a tail at edge N is allocatable from cycle N+1, not the same cycle.
- rr_ptr: set to (last granted index + 1) mod num_req; unchanged when nothing is granted.
- Credits:
  - Decrement on flit_sent; increment on credit_in; both in the same cycle -> unchanged.
  - Underflow (flit_sent with credits=0): err set, counter held at 0.
  - Overflow (credit_in with credits=buf_len): err set, counter held at buf_len.
- Other errors:
  - flit_sent on a FREE PL sets err and is otherwise ignored (credit still decremented).
  - A requester deasserting req before grant is not an error; a bound requester's req is ignored.
- Only rst clears err.
- can_send is combinational from registered state.
- link_owner holds the last owner after release.

Test Plan:
- Reset, num_links=2, credits: all outputs 0, can_send=0; drive credit_in[0] -> err=1 (overflow).
- req=0b0000000110 -> after 1 edge: grant=0b110, requester1 gets link0, requester2 gets link1; rr_ptr=3; link_busy=0b11.
- Both PLs BUSY, req[5]=1. Tail on link0 at edge N -> link_busy[0]=0 at N+1, grant[5] at N+2, link_owner[0]=5.
- Fairness: all 10 req held, each granted requester sends a 1-flit tail packet immediately. Over 10 cycles every requester is granted exactly once, order 0,1,2...9.
- Credits, buf_len=4: 4 flit_sent without credit_in -> can_send=0. Fifth send -> err=1. Simultaneous send+credit_in at credits=2 -> stays 2.
- only_when_empty=1: tail sent with credits=2 -> DRAIN, link_busy stays 1. Two credit_in -> FREE. Pending req granted the following cycle.
